// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: computes a - b one CHUNK-bit slice per cycle, LSB slice first,
// rippling the borrow through a carry register, then reports diff and the usual ALU flags.
module seq_subtractor #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         c_out,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   diff_next;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic [CHUNK:0] sum;
  logic           accept;
  logic           last_chunk;

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_chunk = (cnt == LAST);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  // Two's-complement subtraction of the current slice: a + ~b + carry-in.
  always_comb begin
    sum = {1'b0, a_reg[cnt*CHUNK +: CHUNK]}
        + {1'b0, ~b_reg[cnt*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, carry};
    diff_next = diff;
    diff_next[cnt*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags come from diff_next so they see the final slice written on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      diff  <= '0;
      c_out <= 1'b0;
      zero  <= 1'b0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      cnt   <= '0;
      carry <= 1'b1;
    end else if (state == RUN) begin
      diff  <= diff_next;
      carry <= sum[CHUNK];
      cnt   <= cnt + CW'(1);
      if (last_chunk) begin
        c_out <= sum[CHUNK];
        zero  <= (diff_next == '0);
        neg   <= diff_next[W-1];
        ovf   <= (a_reg[W-1] != b_reg[W-1]) && (diff_next[W-1] != a_reg[W-1]);
      end
    end
  end

endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 Parameter W, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits processed per RUN cycle; W SHALL be an integer multiple of CHUNK; N = W/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request; sampled high on a rising edge in IDLE or DONE begins an operation.
REQ-006 a  input  W  minuend; captured on the accepting edge.
REQ-007 b  input  W  subtrahend; captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 diff  output  W  a - b, modulo 2^W.
REQ-011 c_out  output  1  final carry of a + ~b + 1; 1 = no borrow (a >= b unsigned).
REQ-012 zero  output  1  diff == 0.
REQ-013 neg  output  1  diff[W-1].
REQ-014 ovf  output  1  signed overflow: a[W-1] != b[W-1] and diff[W-1] != a[W-1].

Function
REQ-015 States: IDLE, RUN, DONE; encoded in a registered state variable.
REQ-016 IDLE: start=1 -> latch a, b into operand registers, clear chunk counter to 0, load carry register with 1, go RUN.
REQ-017 RUN: each cycle compute chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) as a_chunk + ~b_chunk + carry; write sum into diff register chunk k; store carry-out in carry register; increment counter.
REQ-018 RUN: chunks processed strictly LSB chunk first; counter runs 0..N-1.
REQ-019 RUN with counter = N-1: after that chunk's update go DONE.
REQ-020 Latency: start accepted at edge t -> done high in the cycle following edge t+N; busy high in the cycles following edges t..t+N-1.
REQ-021 DONE: done=1, busy=0 for exactly one cycle; start=1 -> accept new operation as in REQ-016; otherwise go IDLE.
REQ-022 c_out, zero, neg, ovf SHALL be registered on the edge that enters DONE, derived from the complete diff and the final carry.
REQ-023 diff and flags SHALL hold their values from DONE until the next accepted start; they are undefined-for-use (may change) while busy=1.
REQ-024 start while in RUN SHALL be ignored; operands in progress are unaffected; no queuing.
REQ-025 Changes on a, b after the accepting edge SHALL not affect the result.
REQ-026 Carry propagates between chunks only through the carry register; no combinational path from a/b to any output.
REQ-027 N = 1 (CHUNK = W) SHALL be legal: one RUN cycle.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, operand registers 0.
REQ-029 Reset values: busy=0, done=0, diff=0, c_out=0, zero=0, neg=0, ovf=0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows release.
REQ-031 First start is accepted on the first rising edge with rst_n high.

Verification (W=32, CHUNK=8)
REQ-032 a=5, b=3, start 1 cycle -> busy 4 cycles, then done pulse; diff=0x00000002, c_out=1, zero=0, neg=0, ovf=0.
REQ-033 a=3, b=5 -> diff=0xFFFFFFFE, c_out=0, neg=1, zero=0, ovf=0; a=0x000000FF, b=0xFFFFFFFF -> diff=0x00000100, c_out=0 (cross-chunk borrow).
REQ-034 a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, c_out=1, neg=0; a=b=0x12345678 -> diff=0, zero=1, c_out=1.
REQ-035 start held high during RUN with different a/b -> result matches first operands; new operation begins at DONE (back-to-back, done every 5 cycles).
REQ-036 rst_n pulsed low during RUN cycle 2 -> all outputs 0 immediately, no done pulse; next start completes normally.
